uart_rx_fifo: RTL

- Buffers bytes produced by the UART receiver in a first-word-fall-through FIFO.
- Consumes the receiver's one-cycle byte-valid pulse and its 8-bit byte.
- The CPU-side memory-mapped I/O logic pops bytes, reads status and clears a sticky overflow flag.
- Raises a one-cycle interrupt pulse per accepted byte so the CPU does not miss bursts at 1 MBaud.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_fifo_mem.sv | 38 +++
 rtl/uart_rx_fifo.sv | 103 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the data width, the default receive FIFO depth (as log2) and the
// bit period in clock cycles that the receiver and transmitter also use.
package uart_pkg;

    localparam int UART_DATA_W    = 8;
    localparam int FIFO_ADDR_BITS = 4;
    localparam int CLKS_PER_BIT   = 50;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART receive FIFO.
// DEPTH x UART_DATA_W registers with one synchronous write port and one
// asynchronous (combinational) read port. The read port is asynchronous so
// the FIFO can present its oldest byte in the same cycle it is addressed.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
import uart_pkg::*;

module uart_fifo_mem #(
    parameter int ADDR_BITS = FIFO_ADDR_BITS
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [ADDR_BITS-1:0]   waddr,
    input  logic [UART_DATA_W-1:0] wdata,
    input  logic [ADDR_BITS-1:0]   raddr,
    output logic [UART_DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    // Contents are deliberately never cleared; emptiness is tracked by count.
    logic [UART_DATA_W-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO between the UART receiver and the CPU.
// Accepts the receiver's one-cycle byte-valid pulse, lets the CPU pop bytes,
// keeps a sticky overflow flag and pulses o_irq once per accepted byte.
// Ports:
//   i_Clock    - system clock
//   reset      - synchronous active-high reset
//   i_Rx_DV    - byte-valid pulse from the receiver
//   i_Rx_Byte  - received byte
//   i_rd       - pop strobe (one byte per high cycle)
//   i_clr_ovf  - clears o_overflow
//   o_data     - oldest byte, 8'h00 when empty
//   o_empty    - FIFO holds no bytes
//   o_full     - FIFO holds DEPTH bytes
//   o_count    - number of bytes held
//   o_overflow - sticky: a byte was dropped because the FIFO was full
//   o_irq      - one-cycle pulse the cycle after each accepted byte
import uart_pkg::*;

module uart_rx_fifo #(
    parameter int ADDR_BITS = FIFO_ADDR_BITS
) (
    input  logic                   i_Clock,
    input  logic                   reset,
    input  logic                   i_Rx_DV,
    input  logic [UART_DATA_W-1:0] i_Rx_Byte,
    input  logic                   i_rd,
    input  logic                   i_clr_ovf,
    output logic [UART_DATA_W-1:0] o_data,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [ADDR_BITS:0]     o_count,
    output logic                   o_overflow,
    output logic                   o_irq
);

    localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS+1)'(1 << ADDR_BITS);

    logic [ADDR_BITS-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [ADDR_BITS-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [ADDR_BITS:0]     count_reg, count_next;
    logic                   overflow_reg, overflow_next;
    logic                   irq_reg;
    logic                   push, pop, drop;
    logic [UART_DATA_W-1:0] mem_rdata;

    // A pop on a full FIFO frees the slot the same edge, so the push is
    // still accepted. A pop on an empty FIFO is ignored, so push alone wins.
    always_comb begin
        pop           = i_rd && (count_reg != '0);
        push          = i_Rx_DV && ((count_reg != DEPTH_CNT) || pop);
        drop          = i_Rx_DV && !push;
        wr_ptr_next   = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
        rd_ptr_next   = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
        count_next    = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
        // A new drop outranks a clear arriving in the same cycle.
        overflow_next = overflow_reg;
        if (drop) begin
            overflow_next = 1'b1;
        end else if (i_clr_ovf) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            irq_reg      <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            irq_reg      <= push;
        end
    end

    uart_fifo_mem #(
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk   (i_Clock),
        .we    (push && !reset),
        .waddr (wr_ptr_reg),
        .wdata (i_Rx_Byte),
        .raddr (rd_ptr_reg),
        .rdata (mem_rdata)
    );

    assign o_empty    = (count_reg == '0);
    assign o_full     = (count_reg == DEPTH_CNT);
    assign o_count    = count_reg;
    assign o_overflow = overflow_reg;
    assign o_irq      = irq_reg;
    assign o_data     = o_empty ? '0 : mem_rdata;

endmodule
